serial_parity_checker: RTL
==========================

// Module: serial_parity_checker
// PURPOSE
//   Downstream consumer of the xor gate stage. Takes a serial bit stream one bit per
//   bit_valid and folds the running XOR over a frame of DATA_BITS data bits. It then
//   checks the frame's trailing parity bit against that XOR. It reports the
//   deserialised word plus a parity error flag with a one-cycle done pulse.
//   It sits between the serial line front-end and the word-level consumer.
// PARAMETERS
//   DATA_BITS  8  data bits per frame (>=2), LSB received first
//   ODD        0  0 = even parity, 1 = odd parity
// PORTS
//   clk         in   1          rising-edge clock
//   rst_n       in   1          asynchronous, active-low reset
//   start       in   1          begin a new frame (sampled only in IDLE)
//   bit_in      in   1          serial data/parity bit
//   bit_valid   in   1          bit_in is valid this cycle
//   busy        out  1          high while in DATA or PARITY state
//   done        out  1          one-cycle pulse: frame complete, outputs updated
//   data_out    out  DATA_BITS  last received word, held until next done
//   parity_err  out  1          parity result of last frame, held until next done
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, acc=0, count=0, shift=0.
//     Also busy=0, done=0, data_out=0, parity_err=0.
//     Reset mid-frame discards the partial frame. No done is issued for it.
//   - FSM states: IDLE, DATA, PARITY. All outputs are registered.
//   - IDLE: start=1 -> DATA, and acc/count/shift are cleared. bit_valid is ignored in IDLE.
//     If start and bit_valid are both high in the same cycle, that bit is NOT sampled.
//     The first data bit is taken no earlier than the next cycle.
//   - DATA: on each bit_valid=1: acc <= acc ^ bit_in,
//     shift <= {bit_in, shift[DATA_BITS-1:1]} (LSB first), count <= count+1.
//     When count==DATA_BITS-1 and bit_valid=1 -> PARITY.
//     Cycles with bit_valid=0 hold all state (gaps allowed, no timeout).
//   - PARITY: on bit_valid=1: parity_err <= acc ^ bit_in ^ ODD, data_out <= shift,
//     done <= 1 for exactly one cycle, state -> IDLE.
//     Even parity: error when the total count of ones (data + parity) is odd.
//   - Latency: done, data_out and parity_err are visible in the cycle after the edge
//     that samples the parity bit.
//   - start while busy=1 is ignored and does not restart the frame.
//   - start may be asserted in the cycle done=1 (state is already IDLE) and is accepted.
//     Back-to-back frames need no idle gap.
//   - count width = clog2(DATA_BITS). It never wraps past DATA_BITS-1.
//   - done=0 in every cycle except the one following parity acceptance.
// TESTING
//   1 Even (ODD=0), start, bits of 0xA5 LSB-first, parity=0
//     -> done pulse 1 cycle, data_out=8'hA5, parity_err=0.
//   2 Same frame with parity=1 -> data_out=8'hA5, parity_err=1.
//     Frame 0x07 with parity=1 -> parity_err=0.
//   3 ODD=1 build, frame 0x00 with parity=1 -> parity_err=0.
//     Same frame with parity=0 -> parity_err=1.
//   4 Frame 0x3C with random 0-3 cycle bit_valid gaps.
//     Also start held high during DATA.
//     -> single done, data_out=8'h3C, no restart.
//   5 rst_n low after 4 data bits, then a full frame 0xFF with parity 0
//     -> no done for the aborted frame.
//     After reset busy=0 and data_out=0; then data_out=8'hFF, parity_err=0.
//   6 Frames 0x12 and 0x34 back-to-back, start asserted in the done cycle
//     -> two done pulses, outputs 8'h12 then 8'h34.
//     Also start+bit_valid in the same IDLE cycle -> that bit is not sampled.

Source files
------------

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: deserialises DATA_BITS data bits (LSB first) and checks a
// trailing parity bit against their running XOR; reports word, error flag and done pulse.
module serial_parity_checker #(
  parameter int DATA_BITS = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic                 acc_reg, acc_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_out_reg, data_out_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 done_reg, done_next;
  logic                 busy_reg, busy_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      acc_reg        <= 1'b0;
      count_reg      <= '0;
      shift_reg      <= '0;
      data_out_reg   <= '0;
      parity_err_reg <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      count_reg      <= count_next;
      shift_reg      <= shift_next;
      data_out_reg   <= data_out_next;
      parity_err_reg <= parity_err_next;
      done_reg       <= done_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    count_next      = count_reg;
    shift_next      = shift_reg;
    data_out_next   = data_out_reg;
    parity_err_next = parity_err_reg;
    done_next       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // A bit_valid coinciding with start is deliberately dropped.
        if (start) begin
          state_next = DATA;
          acc_next   = 1'b0;
          count_next = '0;
          shift_next = '0;
        end
      end
      DATA: begin
        if (bit_valid) begin
          acc_next   = acc_reg ^ bit_in;
          shift_next = {bit_in, shift_reg[DATA_BITS-1:1]};
          // Count saturates on the last data bit instead of wrapping.
          if (count_reg == LAST_IDX) begin
            state_next = PARITY;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_valid) begin
          parity_err_next = acc_reg ^ bit_in ^ ODD;
          data_out_next   = shift_reg;
          done_next       = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign data_out   = data_out_reg;
  assign parity_err = parity_err_reg;

endmodule
